// File: rtl/flag_branch_ctrl.sv
// -----------------------------------------------------------------------------
// flag_branch_ctrl
//
// EX-stage controller for the NZCV status register and LEGv8 B.cond
// resolution.
//
// The block does three things:
//   - It generates the status-register write enable for flag-setting EX
//     instructions.
//   - It resolves a B.cond waiting in ID against the freshest flags
//     available. In-flight ALU flags are forwarded in the same cycle they are
//     produced.
//   - It stalls ID while a flag-setting EX instruction is still multi-cycle.
//
// Saturating counters record taken branches and flag-hazard wait cycles.
//
// Handshake (ID <-> this block):
//   - ID raises br_req with br_cond and holds both until br_ack.
//   - The block answers with a one-cycle br_ack pulse. br_taken is valid in
//     that same cycle.
//   - br_kill withdraws a request that has not yet been acknowledged. Once
//     the response cycle is reached, the ack is committed and br_kill is
//     ignored.
//   - Because of the response cycle, two acks are always at least two
//     cycles apart.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex_valid, ex_set_flags          EX holds a valid flag-setting instruction
//   ex_stall                        EX ALU flags not final this cycle
//   ex_flush                        EX instruction squashed this cycle
//   alu_n/z/c/v                     combinational ALU flags of EX
//   sreg_n/z/c/v                    current status-register contents
//   br_req, br_cond[3:0], br_kill   B.cond request from ID
//   sreg_up                         status-register update enable
//   id_stall                        hold IF/ID
//   br_ack, br_taken                registered branch resolution
//   taken_cnt, stall_cnt            saturating performance counters
//   dbg_state                       current FSM state (IDLE=0, WAIT=1, RESP=2)
// -----------------------------------------------------------------------------
module flag_branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             sreg_n,
  input  logic             sreg_z,
  input  logic             sreg_c,
  input  logic             sreg_v,
  input  logic             br_req,
  input  logic [3:0]       br_cond,
  input  logic             br_kill,
  output logic             sreg_up,
  output logic             id_stall,
  output logic             br_ack,
  output logic             br_taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_cond;
  logic             r_ack;
  logic             r_taken;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_writer;
  logic             w_src_ok;
  logic             w_n;
  logic             w_z;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_eval_cond;
  logic             w_eval;

  // A flushed instruction never writes flags, so it is not a hazard.
  assign w_writer = ex_valid & ex_set_flags & ~ex_flush;
  // The only case with no usable flags is a writer whose ALU result is not
  // final yet.
  assign w_src_ok = ~(w_writer & ex_stall);

  // Same-cycle forwarding: a pending writer always wins over the stale
  // register contents.
  assign w_n = w_writer ? alu_n : sreg_n;
  assign w_z = w_writer ? alu_z : sreg_z;
  assign w_c = w_writer ? alu_c : sreg_c;
  assign w_v = w_writer ? alu_v : sreg_v;

  // ID may change br_cond while we wait. The condition captured on entry
  // to WAIT is the one that counts.
  assign w_eval_cond = (r_state == ST_WAIT) ? r_cond : br_cond;

  always_comb begin
    w_eval = 1'b1;
    case (w_eval_cond)
      4'd0:    w_eval = w_z;
      4'd1:    w_eval = ~w_z;
      4'd2:    w_eval = w_c;
      4'd3:    w_eval = ~w_c;
      4'd4:    w_eval = w_n;
      4'd5:    w_eval = ~w_n;
      4'd6:    w_eval = w_v;
      4'd7:    w_eval = ~w_v;
      4'd8:    w_eval = w_c & ~w_z;
      4'd9:    w_eval = ~(w_c & ~w_z);
      4'd10:   w_eval = (w_n == w_v);
      4'd11:   w_eval = (w_n != w_v);
      4'd12:   w_eval = ~w_z & (w_n == w_v);
      4'd13:   w_eval = ~(~w_z & (w_n == w_v));
      default: w_eval = 1'b1;
    endcase
  end

  // rst_n is folded in so that no write can slip through while reset is held.
  assign sreg_up  = rst_n & ex_valid & ex_set_flags & ~ex_stall & ~ex_flush;

  assign id_stall = ((r_state == ST_IDLE) & br_req & ~br_kill) |
                    ((r_state == ST_WAIT) & ~br_kill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cond      <= 4'd0;
      r_ack       <= 1'b0;
      r_taken     <= 1'b0;
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (br_req && !br_kill) begin
            if (w_src_ok) begin
              r_taken <= w_eval;
              r_ack   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              // The request cycle is already a lost cycle, so it is
              // counted as a wait cycle. This makes a k-cycle hazard add
              // exactly k to stall_cnt.
              r_cond  <= br_cond;
              r_state <= ST_WAIT;
              if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
          end
        end
        ST_WAIT: begin
          if (br_kill) begin
            r_state <= ST_IDLE;
          end else if (w_src_ok) begin
            r_taken <= w_eval;
            r_ack   <= 1'b1;
            r_state <= ST_RESP;
          end else if (r_stall_cnt != CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
          end
        end
        ST_RESP: begin
          if (r_taken && (r_taken_cnt != CNT_MAX)) r_taken_cnt <= r_taken_cnt + CNT_ONE;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign br_ack    = r_ack;
  assign br_taken  = r_taken;
  assign taken_cnt = r_taken_cnt;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_branch_ctrl
//
// Drives two instances from shared inputs:
//   - u_dut   with CNT_W=16
//   - u_dut_s with CNT_W=2, so counter saturation is reachable quickly.
//
// Expected branch outcomes come from a condition-code table keyed on the
// condition pair (cond/2), with the odd member inverting. Expected counters
// are kept as unbounded integers and clipped at each check.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_flag_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_set_flags, ex_stall, ex_flush;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        sreg_n, sreg_z, sreg_c, sreg_v;
  logic        br_req, br_kill;
  logic [3:0]  br_cond;

  logic        sreg_up, id_stall, br_ack, br_taken;
  logic [15:0] taken_cnt, stall_cnt;
  logic [1:0]  dbg_state;

  logic        sreg_up_s, id_stall_s, br_ack_s, br_taken_s;
  logic [1:0]  taken_cnt_s, stall_cnt_s;
  logic [1:0]  dbg_state_s;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_taken = 0;
  int exp_stall = 0;
  logic [0:0] exp_q[$];

  flag_branch_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .sreg_n(sreg_n), .sreg_z(sreg_z), .sreg_c(sreg_c), .sreg_v(sreg_v),
    .br_req(br_req), .br_cond(br_cond), .br_kill(br_kill),
    .sreg_up(sreg_up), .id_stall(id_stall), .br_ack(br_ack), .br_taken(br_taken),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  flag_branch_ctrl #(.CNT_W(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .sreg_n(sreg_n), .sreg_z(sreg_z), .sreg_c(sreg_c), .sreg_v(sreg_v),
    .br_req(br_req), .br_cond(br_cond), .br_kill(br_kill),
    .sreg_up(sreg_up_s), .id_stall(id_stall_s), .br_ack(br_ack_s), .br_taken(br_taken_s),
    .taken_cnt(taken_cnt_s), .stall_cnt(stall_cnt_s), .dbg_state(dbg_state_s)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // f = {N, Z, C, V}
  function automatic bit ref_cond(input int cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    if (cond >= 14) return 1'b1;
    case (cond / 2)
      0:       base = z;
      1:       base = c;
      2:       base = n;
      3:       base = v;
      4:       base = c && !z;
      5:       base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (cond % 2 == 1) ? !base : base;
  endfunction

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_taken_cnt"},   32'(taken_cnt),   32'(sat(exp_taken, 65535)));
    chk({tag, "_stall_cnt"},   32'(stall_cnt),   32'(sat(exp_stall, 65535)));
    chk({tag, "_taken_cnt_s"}, 32'(taken_cnt_s), 32'(sat(exp_taken, 3)));
    chk({tag, "_stall_cnt_s"}, 32'(stall_cnt_s), 32'(sat(exp_stall, 3)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid     = 1'b0;
    ex_set_flags = 1'b0;
    ex_stall     = 1'b0;
    ex_flush     = 1'b0;
  endtask

  // One B.cond transaction. The caller is at the start of an IDLE cycle.
  //   writer   : a flag-setting instruction sits in EX
  //   k        : cycles its flags stay non-final (0 = ready now)
  //   flush_rel: the stalled writer is flushed instead of completing
  //   kill_at  : WAIT cycle index (1..k) in which ID kills the branch, 0 = never
  //   noise    : assert br_req/br_kill during the ack cycle
  task automatic run_branch(input logic [3:0] cond, input logic [3:0] sf, input logic [3:0] af,
                            input bit writer, input int k, input bit flush_rel,
                            input int kill_at, input bit noise);
    bit stalled;
    int waited;
    logic [0:0] exp_t;
    stalled = writer && (k > 0);
    {sreg_n, sreg_z, sreg_c, sreg_v} = sf;
    {alu_n, alu_z, alu_c, alu_v}     = af;
    if (writer) begin
      ex_valid     = 1'b1;
      ex_set_flags = 1'b1;
      ex_stall     = stalled;
    end else begin
      // Non-flag-setting EX traffic must never be treated as a hazard.
      ex_valid     = 1'($urandom_range(0, 1));
      ex_set_flags = 1'b0;
      ex_stall     = 1'($urandom_range(0, 1));
    end
    ex_flush = 1'b0;
    br_req   = 1'b1;
    br_cond  = cond;
    br_kill  = 1'b0;
    #1;
    chk("id_stall_req", 32'(id_stall), 32'd1);
    chk("sreg_up_req",  32'(sreg_up),  32'(writer && !stalled));
    if (!stalled) begin
      exp_t = ref_cond(int'(cond), writer ? af : sf);
    end else begin
      waited = 1;
      for (int i = 1; i <= k; i++) begin
        tick();
        br_cond = 4'($urandom_range(0, 15));
        if (i == kill_at) begin
          br_kill = 1'b1;
          #1;
          chk("id_stall_kill", 32'(id_stall), 32'd0);
          chk("ack_in_wait",   32'(br_ack),   32'd0);
          tick();
          br_req  = 1'b0;
          br_kill = 1'b0;
          clear_ex();
          exp_stall += waited;
          #1;
          chk("ack_after_kill", 32'(br_ack),   32'd0);
          chk("stall_after_kill", 32'(id_stall), 32'd0);
          chk_counters("kill");
          return;
        end
        if (i == k) begin
          if (flush_rel) ex_flush = 1'b1;
          else           ex_stall = 1'b0;
        end else begin
          waited++;
        end
        #1;
        chk("id_stall_wait", 32'(id_stall), 32'd1);
        chk("ack_in_wait",   32'(br_ack),   32'd0);
        chk("sreg_up_wait",  32'(sreg_up),  32'((i == k) && !flush_rel));
      end
      exp_stall += waited;
      exp_t = ref_cond(int'(cond), flush_rel ? sf : af);
    end
    exp_q.push_back(exp_t);
    tick();
    br_req  = noise;
    br_kill = noise;
    br_cond = 4'($urandom_range(0, 15));
    clear_ex();
    #1;
    chk("br_ack", 32'(br_ack), 32'd1);
    chk("br_taken", 32'(br_taken), 32'(exp_q.pop_front()));
    chk("id_stall_resp", 32'(id_stall), 32'(noise && 1'b0));
    if (exp_t == 1'b1) exp_taken++;
    tick();
    br_req  = 1'b0;
    br_kill = 1'b0;
    #1;
    chk("ack_pulse_end", 32'(br_ack), 32'd0);
    chk_counters("post");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    br_req = 1'b0;
    br_kill = 1'b0;
    // A ready flag-setting writer during reset must still not write.
    ex_valid = 1'b1;
    ex_set_flags = 1'b1;
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    exp_taken = 0;
    exp_stall = 0;
    exp_q.delete();
    #1;
    chk("rst_sreg_up", 32'(sreg_up),  32'd0);
    chk("rst_br_ack",  32'(br_ack),   32'd0);
    chk("rst_br_taken", 32'(br_taken), 32'd0);
    chk("rst_id_stall", 32'(id_stall), 32'd0);
    chk_counters("rst");
    tick();
    tick();
    rst_n = 1'b1;
    clear_ex();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] cond, sf, af;
    int k, mode;
    rst_n = 1'b0;
    clear_ex();
    {alu_n, alu_z, alu_c, alu_v}     = 4'b0000;
    {sreg_n, sreg_z, sreg_c, sreg_v} = 4'b0000;
    br_req = 1'b0;
    br_kill = 1'b0;
    br_cond = 4'd0;
    tick();
    apply_reset();

    // EQ against sreg Z=1, no writer.
    run_branch(4'd0, 4'b0100, 4'b0000, 1'b0, 0, 1'b0, 0, 1'b0);
    // LT: forwarded ALU N=1,V=0 must beat stale sreg N=0,V=0.
    run_branch(4'd11, 4'b0000, 4'b1000, 1'b1, 0, 1'b0, 0, 1'b0);
    // HI with ADDS stalled 3 cycles; sreg alone would give not-taken.
    run_branch(4'd8, 4'b0100, 4'b0010, 1'b1, 3, 1'b0, 0, 1'b0);
    // Stalled writer flushed in WAIT: sreg Z=0 decides EQ -> not taken.
    run_branch(4'd0, 4'b0000, 4'b0100, 1'b1, 2, 1'b1, 0, 1'b0);
    // Kill in WAIT.
    run_branch(4'd14, 4'b0000, 4'b0000, 1'b1, 3, 1'b0, 2, 1'b0);
    // Ack cycle ignores br_req/br_kill.
    run_branch(4'd15, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 0, 1'b1);

    // Reset asserted mid-WAIT.
    br_req = 1'b1;
    br_cond = 4'd1;
    ex_valid = 1'b1;
    ex_set_flags = 1'b1;
    ex_stall = 1'b1;
    tick();
    tick();
    apply_reset();

    // Five always-taken branches: the 2-bit counter stops at 3.
    for (int i = 0; i < 5; i++) run_branch(4'd14, 4'($urandom_range(0, 15)), 4'd0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("sat_taken_s", 32'(taken_cnt_s), 32'd3);
    chk("sat_taken",   32'(taken_cnt),   32'd5);

    // Randomized transactions.
    for (int it = 0; it < 60; it++) begin
      mode = int'($urandom_range(0, 4));
      cond = 4'($urandom_range(0, 15));
      sf   = 4'($urandom_range(0, 15));
      af   = 4'($urandom_range(0, 15));
      k    = int'($urandom_range(1, 4));
      case (mode)
        0:       run_branch(cond, sf, af, 1'b0, 0, 1'b0, 0, 1'($urandom_range(0, 1)));
        1:       run_branch(cond, sf, af, 1'b1, 0, 1'b0, 0, 1'($urandom_range(0, 1)));
        2:       run_branch(cond, sf, af, 1'b1, k, 1'b0, 0, 1'($urandom_range(0, 1)));
        3:       run_branch(cond, sf, af, 1'b1, k, 1'b1, 0, 1'($urandom_range(0, 1)));
        default: run_branch(cond, sf, af, 1'b1, k, 1'b0, int'($urandom_range(1, k)), 1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
